// File: rtl/uart_dbg_master_if.sv
// Bus side of the UART debug master: one address/data strobe bus with a
// registered read responder on the slave side.
interface uart_dbg_master_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_wen,
        output bus_ren,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_wen,
        input  bus_ren,
        output bus_rdata
    );
endinterface

// File: rtl/uart_dbg_master.sv
// UART-driven debug bus master: A5/5A command frames become single bus writes/reads.
// Optional inter-byte timeout in ADDR/WDATA is enabled with `define UART_DBG_TIMEOUT_EN.
module uart_dbg_master #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic               hb_clk,
    input  logic               rst_n,
    input  logic               uart_rx,
    output logic               uart_tx,
    output logic               busy,
    output logic               frame_err,
    uart_dbg_master_if.master  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_REARM} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_WDATA, P_EXEC, P_RESP} p_state_t;

    rx_state_t        rx_state;
    logic             rx_sync_p0, rx_sync_p1, rx_last;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             byte_valid, rx_ferr;
    logic             rx_tick;

    p_state_t         state;
    logic             is_read, exec_phase;
    logic [1:0]       byte_cnt, resp_idx, resp_last;
    logic [31:0]      addr_q, wdata_q, resp_data;
    logic             bus_wen_r, bus_ren_r;
    logic             timeout_hit;

    logic             tx_load, tx_active, tx_done;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bitn;
    logic [9:0]       tx_frame;
    logic [7:0]       tx_byte;

    assign rx_tick       = (rx_cnt == BIT_LAST);
    assign busy          = (state != P_IDLE);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wen   = bus_wen_r;
    assign bus.bus_ren   = bus_ren_r;
    assign tx_byte       = resp_data[{resp_idx, 3'b000} +: 8];

    // RX: two-flop synchroniser (p0 -> p1), then mid-bit sampling
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_last    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_sync_p0 <= uart_rx;
            rx_sync_p1 <= rx_sync_p0;
            rx_last    <= rx_sync_p1;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_last && !rx_sync_p1) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                RX_DATA: if (rx_tick) begin
                    rx_cnt <= '0;
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                RX_STOP: if (rx_tick) begin
                    rx_cnt <= '0;
                    if (rx_sync_p1) begin
                        byte_valid <= 1'b1;
                        rx_state   <= RX_IDLE;
                    end else begin
                        rx_ferr  <= 1'b1;
                        rx_state <= RX_REARM;
                    end
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                RX_REARM: if (rx_sync_p1) rx_state <= RX_IDLE;
                default:  rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_DBG_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            collecting;

    assign collecting  = (state == P_ADDR) || (state == P_WDATA);
    assign timeout_hit = collecting && (to_cnt == TO_W'(TO_LIMIT - 1));

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n)                          to_cnt <= '0;
        else if (byte_valid || !collecting)  to_cnt <= '0;
        else if (!timeout_hit)               to_cnt <= to_cnt + TO_W'(1);
    end
`else
    // Constant-false: no timeout logic in this build, the parser waits forever.
    assign timeout_hit = (TIMEOUT_BITS < 0);
`endif

    // Parser: command framing, single-cycle strobes, response sequencing
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= P_IDLE;
            is_read    <= 1'b0;
            exec_phase <= 1'b0;
            byte_cnt   <= '0;
            resp_idx   <= '0;
            resp_last  <= '0;
            tx_load    <= 1'b0;
            bus_wen_r  <= 1'b0;
            bus_ren_r  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            bus_wen_r <= 1'b0;
            bus_ren_r <= 1'b0;
            frame_err <= rx_ferr | timeout_hit;
            case (state)
                P_IDLE: if (byte_valid) begin
                    byte_cnt <= '0;
                    if (rx_shift == 8'hA5) begin
                        is_read <= 1'b0;
                        state   <= P_ADDR;
                    end else if (rx_shift == 8'h5A) begin
                        is_read <= 1'b1;
                        state   <= P_ADDR;
                    end
                end
                P_ADDR, P_WDATA: begin
                    if (rx_ferr || timeout_hit) begin
                        state <= P_IDLE;
                    end else if (byte_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (state == P_ADDR && !is_read) begin
                                state <= P_WDATA;
                            end else begin
                                state      <= P_EXEC;
                                exec_phase <= 1'b0;
                                bus_wen_r  <= !is_read;
                                bus_ren_r  <= is_read;
                            end
                        end
                    end
                end
                P_EXEC: begin
                    if (!exec_phase) begin
                        exec_phase <= 1'b1;
                    end else begin
                        state     <= P_RESP;
                        resp_idx  <= '0;
                        resp_last <= is_read ? 2'd3 : 2'd0;
                        tx_load   <= 1'b1;
                    end
                end
                P_RESP: if (tx_done) begin
                    if (resp_idx == resp_last) begin
                        state <= P_IDLE;
                    end else begin
                        resp_idx <= resp_idx + 2'd1;
                        tx_load  <= 1'b1;
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are only read once qualified by control
    always_ff @(posedge hb_clk) begin
        if (rx_state == RX_DATA && rx_tick)
            rx_shift <= {rx_sync_p1, rx_shift[7:1]};
        if (byte_valid && state == P_ADDR)
            addr_q[{byte_cnt, 3'b000} +: 8] <= rx_shift;
        if (byte_valid && state == P_WDATA)
            wdata_q[{byte_cnt, 3'b000} +: 8] <= rx_shift;
        if (state == P_EXEC && exec_phase)
            resp_data <= is_read ? bus.bus_rdata : 32'h0000_004B;
        if (!tx_active && tx_load)
            tx_frame <= {1'b1, tx_byte, 1'b0};
    end

    // TX: start, 8 data LSB first, stop; line rests high between frames
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx   <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            tx_cnt    <= '0;
            tx_bitn   <= '0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_active) begin
                if (tx_load) begin
                    uart_tx   <= 1'b0;
                    tx_active <= 1'b1;
                    tx_cnt    <= '0;
                    tx_bitn   <= '0;
                end
            end else if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bitn == 4'd9) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                    uart_tx   <= 1'b1;
                end else begin
                    tx_bitn <= tx_bitn + 4'd1;
                    uart_tx <= tx_frame[tx_bitn + 4'd1];
                end
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_dbg_master.sv
// Scoreboard bench for uart_dbg_master: directed UART command frames, bus and
// serial-response monitors popping hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_dbg_master;
    localparam int CPB = 8;

    logic hb_clk = 1'b0;
    logic rst_n  = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx, busy, frame_err;

    uart_dbg_master_if bus_if();

    uart_dbg_master #(.CLKS_PER_BIT(CPB)) dut (
        .hb_clk    (hb_clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .frame_err (frame_err),
        .bus       (bus_if)
    );

    always #5 hb_clk = ~hb_clk;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    bus_exp_t    exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          checks = 0;
    int          errors = 0;
    int          fe_cnt = 0;
    int          fe0;
    bit          tx_mon_active = 1'b0;
    logic [31:0] rd_val = 32'h1234_5678;

    logic [7:0] wr_cmd [9] = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] rd_cmd [5] = '{8'h5A, 8'h04, 8'h00, 8'h00, 8'h80};
    logic [7:0] rd2_cmd[5] = '{8'h5A, 8'h20, 8'h00, 8'h00, 8'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered read responder
    always @(posedge hb_clk) bus_if.bus_rdata <= bus_if.bus_ren ? rd_val : 32'h0;

    always @(negedge hb_clk) if (frame_err) fe_cnt++;

    // Bus monitor
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr;
    always @(negedge hb_clk) begin
        bus_exp_t e;
        if (hold_pending) begin
            check("addr_hold", bus_if.bus_addr, hold_addr);
            check("strobe_width", {30'b0, bus_if.bus_wen, bus_if.bus_ren}, 32'd0);
            hold_pending = 1'b0;
        end else if (bus_if.bus_wen || bus_if.bus_ren) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: wen=%b ren=%b addr=%h, expected none",
                         bus_if.bus_wen, bus_if.bus_ren, bus_if.bus_addr);
            end else begin
                e = exp_bus.pop_front();
                check("strobe_wen", bus_if.bus_wen, e.is_write);
                check("strobe_ren", bus_if.bus_ren, !e.is_write);
                check("bus_addr", bus_if.bus_addr, e.addr);
                if (e.is_write) check("bus_wdata", bus_if.bus_wdata, e.data);
            end
            hold_pending = 1'b1;
            hold_addr    = bus_if.bus_addr;
        end
    end

    // Serial response monitor
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            tx_mon_active = 1'b1;
            repeat (CPB/2) @(posedge hb_clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge hb_clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(posedge hb_clk);
            check("tx_stop", uart_tx, 1'b1);
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got %h, expected none", b);
            end else begin
                check("tx_byte", b, exp_tx.pop_front());
            end
            tx_mon_active = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge hb_clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge hb_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge hb_clk);
        end
        uart_rx = !bad_stop;
        repeat (CPB) @(negedge hb_clk);
        uart_rx = 1'b1;
        if (bad_stop) repeat (CPB) @(negedge hb_clk);
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_mon_active || busy)
               && n < max_cycles) begin
            @(negedge hb_clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s_timeout: still pending after %0d cycles, required completion", name, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_bus_wen", bus_if.bus_wen, 1'b0);
        check("rst_bus_ren", bus_if.bus_ren, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        repeat (3) @(negedge hb_clk);
        rst_n = 1'b1;
        repeat (4) @(negedge hb_clk);

        // Write 0xDEADBEEF to 0x80000010, ack 0x4B
        exp_bus.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF});
        exp_tx.push_back(8'h4B);
        foreach (wr_cmd[i]) send_byte(wr_cmd[i], 1'b0);
        wait_done("write", 3000);

        // Read 0x80000004 returning 0x12345678
        exp_bus.push_back('{1'b0, 32'h8000_0004, 32'h0});
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        foreach (rd_cmd[i]) send_byte(rd_cmd[i], 1'b0);
        wait_done("read", 5000);

        // Stray byte 0x33 ignored, then read 0x00000020
        rd_val = 32'hCAFE_0001;
        send_byte(8'h33, 1'b0);
        repeat (4) @(negedge hb_clk);
        check("stray_busy", busy, 1'b0);
        exp_bus.push_back('{1'b0, 32'h0000_0020, 32'h0});
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        foreach (rd2_cmd[i]) send_byte(rd2_cmd[i], 1'b0);
        wait_done("read2", 5000);

        // A5 with a low stop bit
        fe0 = fe_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge hb_clk);
        check("badstop_frame_err", fe_cnt - fe0, 1);
        check("badstop_busy", busy, 1'b0);

        // Reset mid-WDATA abandons the command
        for (int i = 0; i < 7; i++) send_byte(wr_cmd[i], 1'b0);
        check("wdata_busy", busy, 1'b1);
        @(negedge hb_clk);
        rst_n = 1'b0;
        #1;
        check("midrst_uart_tx", uart_tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_bus_wen", bus_if.bus_wen, 1'b0);
        repeat (2) @(negedge hb_clk);
        rst_n = 1'b1;
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        repeat (40) @(negedge hb_clk);
        check("postrst_busy", busy, 1'b0);

        // Idle 41 bit times after A5 10
        fe0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        repeat (41*CPB) @(negedge hb_clk);
`ifdef UART_DBG_TIMEOUT_EN
        check("timeout_frame_err", fe_cnt - fe0, 1);
        check("timeout_busy", busy, 1'b0);
`else
        check("notimeout_frame_err", fe_cnt - fe0, 0);
        check("notimeout_busy", busy, 1'b1);
`endif
        @(negedge hb_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge hb_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge hb_clk);

        check("exp_bus_empty", exp_bus.size(), 0);
        check("exp_tx_empty", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_dbg_master.md
UART_DBG_MASTER -- requirements
Module: uart_dbg_master

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, hb_clk cycles per UART bit; even, minimum 8.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 40, inter-byte timeout in bit times; used only under REQ-027.
REQ-003 SHALL have port hb_clk  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port uart_rx  input  1  host-to-block serial line, idles high.
REQ-006 SHALL have port uart_tx  output  1  block-to-host serial line, idles high.
REQ-007 SHALL have port bus_addr  output  32  bus address, held stable while bus_wen or bus_ren is high and one cycle after.
REQ-008 SHALL have port bus_wdata  output  32  bus write data.
REQ-009 SHALL have port bus_wen  output  1  single-cycle write strobe.
REQ-010 SHALL have port bus_ren  output  1  single-cycle read strobe.
REQ-011 SHALL have port bus_rdata  input  32  read data, valid exactly one cycle after bus_ren (registered responder).
REQ-012 SHALL have port busy  output  1  high in every parser state except IDLE.
REQ-013 SHALL have port frame_err  output  1  single-cycle pulse on bad stop bit or timeout abort.

Function
REQ-014 RX SHALL pass uart_rx through two flops, detect the falling edge, and sample the start bit at CLKS_PER_BIT/2; a high sample there SHALL abort the byte silently.
REQ-015 RX SHALL then sample 8 data bits LSB first and the stop bit, each at CLKS_PER_BIT after the previous sample; 1-cycle byte_valid pulse when the stop bit is high.
REQ-016 On a low stop bit RX SHALL drop the byte, pulse frame_err, return the parser to IDLE, and rearm only after uart_rx has been seen high.
REQ-017 Parser states SHALL be IDLE, ADDR, WDATA, EXEC, RESP.
REQ-018 IDLE: byte 0xA5 -> ADDR (write); byte 0x5A -> ADDR (read); any other byte SHALL be ignored, staying in IDLE.
REQ-019 ADDR SHALL collect 4 bytes LSB first into bus_addr; then write -> WDATA, read -> EXEC.
REQ-020 WDATA SHALL collect 4 bytes LSB first into bus_wdata, then -> EXEC.
REQ-021 EXEC SHALL assert bus_wen or bus_ren for exactly one cycle on entry; a read SHALL capture bus_rdata on the following cycle; then -> RESP.
REQ-022 RESP SHALL transmit, for a write, single byte 0x4B; for a read, the 4 captured bytes LSB first, back to back; after the last stop bit -> IDLE.
REQ-023 TX frame SHALL be 1 start (0), 8 data LSB first, 1 stop (1), each CLKS_PER_BIT cycles long; uart_tx SHALL be 1 between frames.
REQ-024 Bytes received while in EXEC or RESP SHALL be discarded without affecting state.
REQ-025 Bus strobe latency: bus_wen/bus_ren SHALL rise on the cycle after byte_valid of the final command byte.

Reset
REQ-026 rst_n low SHALL immediately force uart_tx=1, bus_wen=0, bus_ren=0, busy=0, frame_err=0, parser IDLE, RX/TX idle with all counters 0; a transfer in progress SHALL be abandoned with no strobe issued after deassertion.

Configuration
REQ-027 With UART_DBG_TIMEOUT_EN defined: in ADDR or WDATA, if no byte_valid occurs within TIMEOUT_BITS*CLKS_PER_BIT cycles of the previous one, the parser SHALL return to IDLE and pulse frame_err.
REQ-028 Without UART_DBG_TIMEOUT_EN: no timeout counter SHALL exist; the parser SHALL wait indefinitely in ADDR/WDATA.

Verification
REQ-029 Send A5 10 00 00 80 EF BE AD DE -> one bus_wen cycle with bus_addr=0x8000_0010, bus_wdata=0xDEAD_BEEF; then uart_tx emits 0x4B.
REQ-030 Send 5A 04 00 00 80, responder returns 0x1234_5678 -> one bus_ren cycle with bus_addr=0x8000_0004; uart_tx emits 78 56 34 12.
REQ-031 Send 0x33 then a valid read command -> 0x33 ignored, read completes normally.
REQ-032 Send A5 with stop bit forced low -> frame_err pulse, busy stays 0, no strobe.
REQ-033 With UART_DBG_TIMEOUT_EN: send A5 10 then idle 41 bit times -> frame_err pulse, busy falls, no bus_wen; without macro busy stays 1.
REQ-034 Assert rst_n low mid-WDATA -> uart_tx=1, busy=0 immediately; after release no bus_wen ever issued for that command.
